spi_cmd_master: RTL and testbench

SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

---
 rtl/spi_cmd_pkg.sv | 35 +++
 rtl/spi_shift_reg.sv | 45 ++++
 rtl/spi_cmd_master.sv | 209 ++++++++++++++++++++
 tb/tb_spi_cmd_master.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command master: FSM state encoding,
// default frame geometry and timing, and the slave's command codes.
package spi_cmd_pkg;

   // Default frame lengths in bits and clk cycles per timing phase
   localparam int WIDTH_CMD_DEF  = 8;
   localparam int WIDTH_DATA_DEF = 16;
   localparam int DLY_DEF        = 2;

   // Frame sequencer states
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      BIT_LO,
      BIT_HI,
      HOLD,
      GAP
   } state_e;

   // Command codes understood by the attached slave
   localparam logic [7:0] CMD_REG1      = 8'd1;
   localparam logic [7:0] CMD_REG2      = 8'd2;
   localparam logic [7:0] CMD_REG3      = 8'd3;
   localparam logic [7:0] CMD_FIFO_WR   = 8'd4;
   localparam logic [7:0] CMD_RAM_WADDR = 8'd5;
   localparam logic [7:0] CMD_RAM_RADDR = 8'd6;
   localparam logic [7:0] CMD_RAM_DATA  = 8'd7;
   localparam logic [7:0] CMD_READ_FLAG = 8'd128;

   // Turns a plain command code into its read-back variant
   function automatic logic [7:0] read_cmd(input logic [7:0] code);
      return code | CMD_READ_FLAG;
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register shared by the transmit and receive paths: parallel load,
// MSB-first serial out, serial in at the LSB. Synchronous active-high reset.
module spi_shift_reg
   import spi_cmd_pkg::*;
#(
   parameter int WIDTH = WIDTH_DATA_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_i,
   input  logic             serial_i,
   output logic             serial_o,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   // Next value: load wins over shift, otherwise hold
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      sr_d = sr_q;
      if (load_i) begin
         sr_d = load_data_i;
      end else if (shift_i) begin
         sr_d = {sr_q[WIDTH-2:0], serial_i};
      end
   end

   // Register update
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign serial_o = sr_q[WIDTH-1];
   assign data_o   = sr_q;

endmodule

// File: rtl/spi_cmd_master.sv
// SPI command master: sends one command frame (on spi_cs_cmd) or one data
// frame (on spi_cs_data) per accepted request, MSB first, and returns the
// bits shifted in from spi_sdo on data read frames.
// Optional build macro SPI_CMD_MASTER_LOOPBACK_EN adds input lpbk_en, which
// routes the internal spi_sdi back into the receive path.
module spi_cmd_master
   import spi_cmd_pkg::*;
#(
   parameter int WIDTH_CMD  = WIDTH_CMD_DEF,
   parameter int WIDTH_DATA = WIDTH_DATA_DEF,
   parameter int DLY        = DLY_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_cmd,
   input  logic                  req_is_read,
   input  logic [WIDTH_DATA-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [WIDTH_DATA-1:0] rsp_rdata,
   output logic                  busy,
   output logic                  spi_scl,
   output logic                  spi_sdi,
   input  logic                  spi_sdo,
`ifdef SPI_CMD_MASTER_LOOPBACK_EN
   input  logic                  lpbk_en,
`endif
   output logic                  spi_cs_cmd,
   output logic                  spi_cs_data
);

   localparam int BW = $clog2(WIDTH_DATA + 1);

   localparam logic [7:0]    DLY_LAST  = 8'(DLY - 1);
   localparam logic [BW-1:0] CMD_LAST  = BW'(WIDTH_CMD - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH_DATA - 1);

   state_e                state_q,     state_d;
   logic [7:0]            dly_cnt_q,   dly_cnt_d;
   logic [BW-1:0]         bit_cnt_q,   bit_cnt_d;
   logic                  is_cmd_q,    is_cmd_d;
   logic                  is_read_q,   is_read_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [WIDTH_DATA-1:0] rsp_rdata_q, rsp_rdata_d;

   logic                  sr_load;
   logic                  sr_shift;
   logic [WIDTH_DATA-1:0] sr_load_data;
   logic                  sr_msb;
   logic [WIDTH_DATA-1:0] sr_data;
   logic                  rx_bit;
   logic                  dly_done;
   logic                  frame_active;

   // Command payloads sit in the low bits; move them to the top so the
   // first bit shifted out is the command MSB.
   assign sr_load_data = req_is_cmd ? (req_wdata << (WIDTH_DATA - WIDTH_CMD)) : req_wdata;

`ifdef SPI_CMD_MASTER_LOOPBACK_EN
   assign rx_bit = lpbk_en ? spi_sdi : spi_sdo;
`else
   assign rx_bit = spi_sdo;
`endif

   // One register serves both directions: TX bits leave at the MSB while
   // RX bits enter at the LSB, so after a full data frame it holds the reply.
   spi_shift_reg #(
      .WIDTH(WIDTH_DATA)
   ) u_shift (
      .clk        (clk),
      .rst        (rst),
      .load_i     (sr_load),
      .load_data_i(sr_load_data),
      .shift_i    (sr_shift),
      .serial_i   (rx_bit),
      .serial_o   (sr_msb),
      .data_o     (sr_data)
   );

   assign dly_done = (dly_cnt_q == 8'd0);

   // Frame sequencer: next state, counters and shift control
   always_comb begin
      state_d     = state_q;
      dly_cnt_d   = dly_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      is_cmd_d    = is_cmd_q;
      is_read_d   = is_read_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      sr_load     = 1'b0;
      sr_shift    = 1'b0;

      case (state_q)
         IDLE: begin
            // req_ready is high only here, so a request arriving while a
            // frame runs is simply not seen until we return.
            if (req_valid) begin
               state_d   = SETUP;
               dly_cnt_d = DLY_LAST;
               bit_cnt_d = req_is_cmd ? CMD_LAST : DATA_LAST;
               is_cmd_d  = req_is_cmd;
               is_read_d = req_is_read & ~req_is_cmd;
               sr_load   = 1'b1;
            end
         end

         SETUP: begin
            if (dly_done) begin
               state_d   = BIT_LO;
               dly_cnt_d = DLY_LAST;
            end else begin
               dly_cnt_d = dly_cnt_q - 8'd1;
            end
         end

         BIT_LO: begin
            if (dly_done) begin
               state_d   = BIT_HI;
               dly_cnt_d = DLY_LAST;
            end else begin
               dly_cnt_d = dly_cnt_q - 8'd1;
            end
         end

         BIT_HI: begin
            // Sample and advance on the last cycle of the high phase; the
            // new MSB appears together with the falling SCL.
            if (dly_done) begin
               sr_shift  = 1'b1;
               dly_cnt_d = DLY_LAST;
               if (bit_cnt_q == '0) begin
                  state_d = HOLD;
               end else begin
                  state_d   = BIT_LO;
                  bit_cnt_d = bit_cnt_q - BW'(1);
               end
            end else begin
               dly_cnt_d = dly_cnt_q - 8'd1;
            end
         end

         HOLD: begin
            if (dly_done) begin
               state_d   = GAP;
               dly_cnt_d = DLY_LAST;
               if (is_read_q) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = sr_data;
               end
            end else begin
               dly_cnt_d = dly_cnt_q - 8'd1;
            end
         end

         GAP: begin
            if (dly_done) begin
               state_d = IDLE;
            end else begin
               dly_cnt_d = dly_cnt_q - 8'd1;
            end
         end

         default: begin
            state_d   = IDLE;
            dly_cnt_d = '0;
            bit_cnt_d = '0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         dly_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         is_cmd_q    <= 1'b0;
         is_read_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         dly_cnt_q   <= dly_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         is_cmd_q    <= is_cmd_d;
         is_read_q   <= is_read_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Bus pins decode straight from registered state, so each chip select
   // can only fall for the frame type latched at accept.
   assign frame_active = (state_q == SETUP) || (state_q == BIT_LO) ||
                         (state_q == BIT_HI) || (state_q == HOLD);

   assign spi_cs_cmd  = ~(frame_active &  is_cmd_q);
   assign spi_cs_data = ~(frame_active & ~is_cmd_q);
   assign spi_scl     = (state_q == BIT_HI);
   assign spi_sdi     = ((state_q == SETUP) || (state_q == BIT_LO) || (state_q == BIT_HI)) ? sr_msb : 1'b0;

   assign req_ready = (state_q == IDLE);
   assign busy      = ~req_ready;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master. A behavioural slave on the SPI pins
// keeps three registers and a FIFO; the stimulus keeps its own model of the
// same registers to predict read data. Frame and response monitors compare
// the bus and rsp outputs against expectation queues.
// Build with SPI_CMD_MASTER_LOOPBACK_EN to also exercise lpbk_en.
module tb_spi_cmd_master;
   import spi_cmd_pkg::*;

   localparam int WCMD  = 8;
   localparam int WDATA = 16;
   localparam int DLY   = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_cmd = 1'b0;
   logic        req_is_read = 1'b0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        busy;
   logic        spi_scl;
   logic        spi_sdi;
   logic        spi_sdo = 1'b0;
   logic        spi_cs_cmd;
   logic        spi_cs_data;
`ifdef SPI_CMD_MASTER_LOOPBACK_EN
   logic        lpbk_en = 1'b0;
`endif

   always #5 clk = ~clk;

   spi_cmd_master #(
      .WIDTH_CMD (WCMD),
      .WIDTH_DATA(WDATA),
      .DLY       (DLY)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_is_cmd (req_is_cmd),
      .req_is_read(req_is_read),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .busy       (busy),
      .spi_scl    (spi_scl),
      .spi_sdi    (spi_sdi),
      .spi_sdo    (spi_sdo),
`ifdef SPI_CMD_MASTER_LOOPBACK_EN
      .lpbk_en    (lpbk_en),
`endif
      .spi_cs_cmd (spi_cs_cmd),
      .spi_cs_data(spi_cs_data)
   );

   typedef struct {
      bit          is_cmd;
      int          nbits;
      logic [15:0] word;
   } frame_t;

   frame_t      frame_q[$];
   logic [15:0] rsp_q[$];
   int          tests_run    = 0;
   int          tests_failed = 0;
   bit          abort_pending = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural slave on the SPI pins ----------------
   logic [7:0]  sl_last_cmd = '0;
   logic [15:0] sl_reg[0:3] = '{default: 16'h0};
   logic [15:0] sl_fifo[$];
   logic [15:0] sl_reply = '0;
   logic [15:0] sl_word  = '0;
   int          sl_falls = 0;
   bit          sl_active = 1'b0;
   bit          sl_is_cmd = 1'b0;
   logic        sl_prev_scl = 1'b0;

   always @(negedge clk) begin
      if (!spi_cs_cmd || !spi_cs_data) begin
         if (!sl_active) begin
            sl_active = 1'b1;
            sl_is_cmd = !spi_cs_cmd;
            sl_falls  = 0;
            sl_word   = '0;
            sl_reply  = '0;
            if (!sl_is_cmd) begin
               if (sl_last_cmd == CMD_READ_FLAG)
                  sl_reply = sl_reg[1] + sl_reg[2] + sl_reg[3];
               else if (sl_last_cmd == read_cmd(CMD_FIFO_WR))
                  sl_reply = (sl_fifo.size() > 0) ? sl_fifo.pop_front() : 16'h0;
               else if (sl_last_cmd >= read_cmd(CMD_REG1) && sl_last_cmd <= read_cmd(CMD_REG3))
                  sl_reply = sl_reg[sl_last_cmd[1:0]];
            end
         end
         if (spi_scl && !sl_prev_scl) sl_word = {sl_word[14:0], spi_sdi};
         if (!spi_scl && sl_prev_scl) sl_falls++;
      end else if (sl_active) begin
         sl_active = 1'b0;
         if (sl_is_cmd)
            sl_last_cmd = sl_word[7:0];
         else if (sl_last_cmd >= CMD_REG1 && sl_last_cmd <= CMD_REG3)
            sl_reg[sl_last_cmd[1:0]] = sl_word;
         else if (sl_last_cmd == CMD_FIFO_WR)
            sl_fifo.push_back(sl_word);
      end
      sl_prev_scl = spi_scl;
      spi_sdo = (sl_active && !sl_is_cmd && sl_falls < 16) ? sl_reply[15 - sl_falls] : 1'b0;
   end

   // ---------------- frame monitor ----------------
   bit          in_frame = 1'b0;
   bit          fr_cmd   = 1'b0;
   int          fr_low   = 0;
   int          fr_bits  = 0;
   logic [15:0] fr_word  = '0;
   logic        mon_prev_scl = 1'b0;
   logic        mon_prev_sdi = 1'b0;

   always @(negedge clk) begin
      frame_t f;
      if (!spi_cs_cmd || !spi_cs_data) begin
         check("cs_exclusive", spi_cs_cmd ^ spi_cs_data, 1);
         if (!in_frame) begin
            in_frame = 1'b1;
            fr_cmd   = !spi_cs_cmd;
            fr_low   = 0;
            fr_bits  = 0;
            fr_word  = '0;
         end
         fr_low++;
         if (spi_scl && !mon_prev_scl) begin
            fr_bits++;
            fr_word = {fr_word[14:0], spi_sdi};
         end
         if (spi_scl && mon_prev_scl) check("sdi_stable_scl_high", spi_sdi, mon_prev_sdi);
      end else if (in_frame) begin
         in_frame = 1'b0;
         check("scl_low_after_frame", spi_scl, 0);
         if (abort_pending) begin
            abort_pending = 1'b0;
         end else if (frame_q.size() == 0) begin
            check("unexpected_frame", frame_q.size(), 1);
         end else begin
            f = frame_q.pop_front();
            check("frame_is_cmd", fr_cmd, f.is_cmd);
            check("frame_cs_low_cycles", fr_low, (2 + 2 * f.nbits) * DLY);
            check("frame_scl_pulses", fr_bits, f.nbits);
            check("frame_sdi_word", fr_word, f.word);
         end
      end
      mon_prev_scl = spi_scl;
      mon_prev_sdi = spi_sdi;
   end

   // ---------------- response monitor ----------------
   logic prev_rsp_valid = 1'b0;

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (prev_rsp_valid) check("rsp_valid_pulse_width", prev_rsp_valid, 0);
         if (rsp_q.size() == 0) check("unexpected_rsp_valid", rsp_valid, 0);
         else check("rsp_rdata", rsp_rdata, rsp_q.pop_front());
      end
      prev_rsp_valid = rsp_valid;
   end

   // ---------------- stimulus and reference model ----------------
   logic [15:0] model_reg[0:3] = '{default: 16'h0};
   logic [15:0] model_fifo[$];

   task automatic wait_ready();
      int g = 0;
      @(negedge clk);
      while (!req_ready && g < 5000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 5000) check("ready_timeout", req_ready, 1);
   endtask

   task automatic send(input bit is_cmd, input bit is_read, input logic [15:0] wdata,
                       input logic [15:0] exp_rd);
      frame_t f;
      int     n;
      int     lat;
      n        = is_cmd ? WCMD : WDATA;
      f.is_cmd = is_cmd;
      f.nbits  = n;
      f.word   = is_cmd ? {8'h00, wdata[7:0]} : wdata;
      wait_ready();
      req_valid   = 1'b1;
      req_is_cmd  = is_cmd;
      req_is_read = is_read;
      req_wdata   = wdata;
      frame_q.push_back(f);
      if (!is_cmd && is_read) rsp_q.push_back(exp_rd);
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
      req_wdata   = 16'($urandom);
      req_is_read = 1'($urandom);
      lat = 1;
      @(negedge clk);
      while (!req_ready && lat < 5000) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("accept_to_ready_latency", lat, (3 + 2 * n) * DLY + 1);
   endtask

   task automatic cmd(input logic [7:0] code);
      send(1'b1, 1'($urandom), {8'($urandom), code}, 16'h0);
   endtask

   task automatic wr_reg(input logic [1:0] n, input logic [15:0] v);
      cmd({6'd0, n});
      send(1'b0, 1'b0, v, 16'h0);
      model_reg[n] = v;
   endtask

   task automatic rd_reg(input logic [1:0] n);
      cmd(read_cmd({6'd0, n}));
      send(1'b0, 1'b1, 16'($urandom), model_reg[n]);
   endtask

   task automatic rd_sum();
      logic [15:0] s;
      s = model_reg[1] + model_reg[2] + model_reg[3];
      cmd(CMD_READ_FLAG);
      send(1'b0, 1'b1, 16'($urandom), s);
   endtask

   task automatic fifo_wr(input logic [15:0] v);
      cmd(CMD_FIFO_WR);
      send(1'b0, 1'b0, v, 16'h0);
      model_fifo.push_back(v);
   endtask

   task automatic fifo_rd();
      logic [15:0] e;
      e = (model_fifo.size() > 0) ? model_fifo.pop_front() : 16'h0;
      cmd(read_cmd(CMD_FIFO_WR));
      send(1'b0, 1'b1, 16'($urandom), e);
   endtask

   initial begin
      frame_t      fa;
      frame_t      fb;
      int          rises;
      int          g;
      logic        p_scl;
      int          op;
      logic [1:0]  rn;
      logic [15:0] rv;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_cs_cmd", spi_cs_cmd, 1);
      check("rst_cs_data", spi_cs_data, 1);
      check("rst_scl", spi_scl, 0);
      check("rst_sdi", spi_sdi, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      rst = 1'b0;

      // Command 0x01 then data write 0xA5C3
      wr_reg(2'd1, 16'hA5C3);

      // Sum read returning 0x1234
      wr_reg(2'd1, 16'h1000);
      wr_reg(2'd2, 16'h0200);
      wr_reg(2'd3, 16'h0034);
      rd_sum();

      // Register sum 0x0060, then FIFO 1..10 in order
      wr_reg(2'd1, 16'h0010);
      wr_reg(2'd2, 16'h0020);
      wr_reg(2'd3, 16'h0030);
      rd_sum();
      cmd(CMD_FIFO_WR);
      for (int i = 1; i <= 10; i++) begin
         send(1'b0, 1'b0, 16'(i), 16'h0);
         model_fifo.push_back(16'(i));
      end
      cmd(read_cmd(CMD_FIFO_WR));
      for (int i = 1; i <= 10; i++) send(1'b0, 1'b1, 16'($urandom), model_fifo.pop_front());

      // req_valid held through busy with a second payload
      wait_ready();
      fa.is_cmd = 1'b1; fa.nbits = WCMD;  fa.word = {8'h00, CMD_REG2};
      fb.is_cmd = 1'b0; fb.nbits = WDATA; fb.word = 16'h7777;
      req_valid = 1'b1; req_is_cmd = 1'b1; req_is_read = 1'b0; req_wdata = {8'hA0, CMD_REG2};
      frame_q.push_back(fa);
      @(posedge clk);
      #1;
      req_is_cmd = 1'b0; req_wdata = 16'h7777;
      frame_q.push_back(fb);
      wait_ready();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      model_reg[2] = 16'h7777;
      rd_reg(2'd2);

      // Reset at bit 5 of a read frame
      cmd(read_cmd(CMD_REG1));
      wait_ready();
      req_valid = 1'b1; req_is_cmd = 1'b0; req_is_read = 1'b1; req_wdata = 16'($urandom);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rises = 0; g = 0; p_scl = 1'b0;
      while (rises < 5 && g < 2000) begin
         @(negedge clk);
         if (spi_scl && !p_scl) rises++;
         p_scl = spi_scl;
         g++;
      end
      check("reach_bit5", rises, 5);
      abort_pending = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_cs_cmd", spi_cs_cmd, 1);
      check("abort_cs_data", spi_cs_data, 1);
      check("abort_scl", spi_scl, 0);
      check("abort_req_ready", req_ready, 1);
      check("abort_rsp_valid", rsp_valid, 0);
      rst = 1'b0;
      rd_reg(2'd1);

`ifdef SPI_CMD_MASTER_LOOPBACK_EN
      cmd(read_cmd(CMD_RAM_DATA));
      lpbk_en = 1'b1;
      send(1'b0, 1'b1, 16'hBEEF, 16'hBEEF);
      lpbk_en = 1'b0;
`endif

      // Randomized traffic against the register/FIFO model
      for (int k = 0; k < 40; k++) begin
         op = $urandom_range(0, 4);
         rn = 2'($urandom_range(1, 3));
         rv = 16'($urandom);
         case (op)
            0: wr_reg(rn, rv);
            1: rd_reg(rn);
            2: rd_sum();
            3: fifo_wr(rv);
            default: fifo_rd();
         endcase
      end

      // Drain
      g = 0;
      while ((frame_q.size() > 0 || rsp_q.size() > 0) && g < 2000) begin
         @(negedge clk);
         g++;
      end
      repeat (4) @(negedge clk);
      check("frames_drained", frame_q.size(), 0);
      check("rsp_drained", rsp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
